// File: rtl/nanotrade_pkg.sv
// nanotrade_pkg
//   Shared definitions for the trading-control blocks: circuit-breaker state
//   encodings, alert priority thresholds, alert-type codes (these match the
//   bit positions of the detector alert bitmap), and alert classification
//   helpers.
package nanotrade_pkg;

    typedef enum logic [1:0] {
        CB_NORMAL   = 2'b00,
        CB_WATCH    = 2'b01,
        CB_HALT     = 2'b10,
        CB_COOLDOWN = 2'b11
    } cb_state_e;

    localparam logic [2:0] PRIO_FLASH  = 3'd7;
    localparam logic [2:0] PRIO_SEVERE = 3'd4;

    // Alert-type codes, equal to the detector's bit index in alert_bitmap.
    localparam logic [2:0] ALERT_PRICE_JUMP   = 3'd0;
    localparam logic [2:0] ALERT_SPREAD_WIDE  = 3'd1;
    localparam logic [2:0] ALERT_VOLUME_SPIKE = 3'd2;
    localparam logic [2:0] ALERT_QUOTE_STUFF  = 3'd3;
    localparam logic [2:0] ALERT_BOOK_THIN    = 3'd4;
    localparam logic [2:0] ALERT_CROSSED_BOOK = 3'd5;
    localparam logic [2:0] ALERT_RATE_LIMIT   = 3'd6;
    localparam logic [2:0] ALERT_FLASH_CRASH  = 3'd7;

    function automatic logic is_severe(input logic any, input logic [2:0] prio);
        return any && (prio >= PRIO_SEVERE);
    endfunction

    function automatic logic is_flash(input logic any, input logic [2:0] prio);
        return any && (prio == PRIO_FLASH);
    endfunction

endpackage

// File: rtl/circuit_breaker_hold_timer.sv
// hold_timer
//   Down-counter with terminal-count compare, used for both the HALT and the
//   COOLDOWN hold periods.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load `value` into the counter (takes priority over counting)
//   value       value to load
//   run         count down while set (counter holds at zero)
//   expired     counter is zero while running
module hold_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    input  logic               run,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (run && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = run && (count_q == '0);

endmodule

// File: rtl/circuit_breaker.sv
// circuit_breaker
//   Turns the per-cycle anomaly-detector alert bundle into a stable
//   trading-control state with a registered halt, a cooldown throttle, a
//   sticky alert log and a saturating halt-event counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   alert_any       any detector active
//   alert_priority  priority of the highest active alert (7 = flash crash)
//   alert_type      type of the highest active alert
//   alert_bitmap    all detector flags
//   clr             operator clear pulse
//   trading_halt    suppress order matching (state HALT)
//   throttle        reduced-rate trading (state COOLDOWN)
//   cb_state        current state encoding
//   last_cause      alert_type of the most recent HALT entry or retrigger
//   sticky_bitmap   OR of alert_bitmap since reset / clear
//   halt_count      HALT entries, saturating at 255
//
// state    | meaning
// ---------+-----------------------------------------------------------
// NORMAL   | no sustained alert, trading at full rate
// WATCH    | severe alerts seen, counting consecutive confirmations
// HALT     | trading halted for the hold period; flash retriggers
// COOLDOWN | reduced-rate trading; any severe alert re-trips to HALT
module circuit_breaker
    import nanotrade_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 4,
    parameter int HALT_CYCLES    = 1024,
    parameter int COOL_CYCLES    = 256,
    parameter int TIMER_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alert_any,
    input  logic [2:0] alert_priority,
    input  logic [2:0] alert_type,
    input  logic [7:0] alert_bitmap,
    input  logic       clr,
    output logic       trading_halt,
    output logic       throttle,
    output logic [1:0] cb_state,
    output logic [2:0] last_cause,
    output logic [7:0] sticky_bitmap,
    output logic [7:0] halt_count
);

    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HALT_LOAD   = TIMER_W'(HALT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD   = TIMER_W'(COOL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CONFIRM_TGT = CNT_W'(CONFIRM_CYCLES);

    cb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   confirm_q, confirm_d, confirm_inc;
    logic               severe, flash;
    logic               go_halt;
    logic               timer_load, timer_run, timer_expired;
    logic [TIMER_W-1:0] timer_value;

    assign severe      = is_severe(alert_any, alert_priority);
    assign flash       = is_flash(alert_any, alert_priority);
    assign confirm_inc = confirm_q + CNT_W'(1);
    assign timer_run   = (state_q == CB_HALT) || (state_q == CB_COOLDOWN);

    hold_timer #(
        .TIMER_W (TIMER_W)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (timer_value),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CB_NORMAL;
            confirm_q <= '0;
        end else begin
            state_q   <= state_d;
            confirm_q <= confirm_d;
        end
    end

    // Flash overrides everything, including an operator clear in the same
    // cycle; in HALT it acts as a retrigger. All HALT entries share the
    // go_halt path so counting and cause capture stay in one place.
    always_comb begin
        state_d     = state_q;
        confirm_d   = confirm_q;
        timer_load  = 1'b0;
        timer_value = '0;
        go_halt     = flash;

        if (!flash) begin
            if (clr) begin
                state_d    = CB_NORMAL;
                confirm_d  = '0;
                timer_load = 1'b1;
            end else begin
                case (state_q)
                    CB_NORMAL: begin
                        if (severe) begin
                            if (CONFIRM_CYCLES <= 1) begin
                                go_halt = 1'b1;
                            end else begin
                                state_d   = CB_WATCH;
                                confirm_d = CNT_W'(1);
                            end
                        end
                    end
                    CB_WATCH: begin
                        if (!severe) begin
                            state_d   = CB_NORMAL;
                            confirm_d = '0;
                        end else if (confirm_inc == CONFIRM_TGT) begin
                            go_halt = 1'b1;
                        end else begin
                            confirm_d = confirm_inc;
                        end
                    end
                    CB_HALT: begin
                        if (timer_expired) begin
                            state_d     = CB_COOLDOWN;
                            timer_load  = 1'b1;
                            timer_value = COOL_LOAD;
                        end
                    end
                    CB_COOLDOWN: begin
                        if (severe) begin
                            go_halt = 1'b1;
                        end else if (timer_expired) begin
                            state_d = CB_NORMAL;
                        end
                    end
                    default: begin
                        state_d = CB_NORMAL;
                    end
                endcase
            end
        end

        if (go_halt) begin
            state_d     = CB_HALT;
            confirm_d   = '0;
            timer_load  = 1'b1;
            timer_value = HALT_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_bitmap <= '0;
            halt_count    <= '0;
            last_cause    <= '0;
        end else begin
            if (clr && flash) begin
                sticky_bitmap <= alert_bitmap;
            end else if (clr) begin
                sticky_bitmap <= '0;
            end else begin
                sticky_bitmap <= sticky_bitmap | alert_bitmap;
            end

            if (go_halt) begin
                last_cause <= alert_type;
                if (halt_count != 8'hFF) begin
                    halt_count <= halt_count + 8'd1;
                end
            end
        end
    end

    assign cb_state     = state_q;
    assign trading_halt = (state_q == CB_HALT);
    assign throttle     = (state_q == CB_COOLDOWN);

endmodule

// File: tb/tb_circuit_breaker.sv
module tb_circuit_breaker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alert_any = 1'b0;
    logic [2:0] alert_priority = 3'd0;
    logic [2:0] alert_type = 3'd0;
    logic [7:0] alert_bitmap = 8'd0;
    logic       clr = 1'b0;
    logic       trading_halt;
    logic       throttle;
    logic [1:0] cb_state;
    logic [2:0] last_cause;
    logic [7:0] sticky_bitmap;
    logic [7:0] halt_count;

    int vectors = 0;
    int errors  = 0;

    circuit_breaker #(
        .CONFIRM_CYCLES (4),
        .HALT_CYCLES    (16),
        .COOL_CYCLES    (8),
        .TIMER_W        (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alert_any      (alert_any),
        .alert_priority (alert_priority),
        .alert_type     (alert_type),
        .alert_bitmap   (alert_bitmap),
        .clr            (clr),
        .trading_halt   (trading_halt),
        .throttle       (throttle),
        .cb_state       (cb_state),
        .last_cause     (last_cause),
        .sticky_bitmap  (sticky_bitmap),
        .halt_count     (halt_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are then sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alert(input logic a, input logic [2:0] p,
                             input logic [2:0] t, input logic [7:0] b);
        alert_any      = a;
        alert_priority = p;
        alert_type     = t;
        alert_bitmap   = b;
    endtask

    task automatic idle();
        set_alert(1'b0, 3'd0, 3'd0, 8'h00);
        clr = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({trading_halt, throttle, cb_state, last_cause, sticky_bitmap, halt_count} !== 23'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0",
                     {trading_halt, throttle, cb_state, last_cause, sticky_bitmap, halt_count});
        end
        set_alert(1'b1, 3'd7, 3'd7, 8'h80);
        step();
        idle();
        repeat (5) step();
        vectors++;
        if (trading_halt !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_halt: trading_halt got %b expected 1", trading_halt);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({trading_halt, throttle, cb_state, last_cause, sticky_bitmap, halt_count} !== 23'h0) begin
            errors++;
            $display("FAIL reset_mid_halt: got %h expected 0",
                     {trading_halt, throttle, cb_state, last_cause, sticky_bitmap, halt_count});
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        vectors++;
        if (cb_state !== 2'b00 || trading_halt !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: state got %b halt %b expected 00/0", cb_state, trading_halt);
        end
    endtask

    task automatic test_flash_cycle();
        int halt_len;
        int cool_len;
        do_reset();
        set_alert(1'b1, 3'd7, 3'd7, 8'h80);
        step();
        idle();
        vectors++;
        if ({trading_halt, cb_state, last_cause, halt_count, sticky_bitmap} !== {1'b1, 2'b10, 3'd7, 8'd1, 8'h80}) begin
            errors++;
            $display("FAIL flash_trip: got halt=%b st=%b cause=%0d cnt=%0d sticky=%h expected 1/10/7/1/80",
                     trading_halt, cb_state, last_cause, halt_count, sticky_bitmap);
        end
        halt_len = 1;
        while (trading_halt === 1'b1 && halt_len < 100) begin
            step();
            if (trading_halt === 1'b1) halt_len++;
        end
        vectors++;
        if (halt_len != 16) begin
            errors++;
            $display("FAIL flash_halt_len: got %0d expected 16", halt_len);
        end
        cool_len = 0;
        while (throttle === 1'b1 && cool_len < 100) begin
            cool_len++;
            step();
        end
        vectors++;
        if (cool_len != 8) begin
            errors++;
            $display("FAIL flash_cool_len: got %0d expected 8", cool_len);
        end
        vectors++;
        if (cb_state !== 2'b00 || trading_halt !== 1'b0 || throttle !== 1'b0) begin
            errors++;
            $display("FAIL flash_back_normal: state got %b expected 00", cb_state);
        end
    endtask

    task automatic test_watch();
        do_reset();
        // Not severe: priority 7 without alert_any, and priority 3 with it.
        set_alert(1'b0, 3'd7, 3'd7, 8'h00);
        step();
        set_alert(1'b1, 3'd3, 3'd1, 8'h00);
        step();
        vectors++;
        if (cb_state !== 2'b00 || halt_count !== 8'd0) begin
            errors++;
            $display("FAIL watch_non_severe: state got %b cnt %0d expected 00/0", cb_state, halt_count);
        end
        set_alert(1'b1, 3'd4, 3'd2, 8'h04);
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (cb_state !== 2'b01) begin
                errors++;
                $display("FAIL watch_hold_%0d: state got %b expected 01", i, cb_state);
            end
        end
        idle();
        step();
        vectors++;
        if (cb_state !== 2'b00 || trading_halt !== 1'b0) begin
            errors++;
            $display("FAIL watch_abort: state got %b expected 00", cb_state);
        end
        set_alert(1'b1, 3'd4, 3'd2, 8'h04);
        repeat (3) step();
        vectors++;
        if (trading_halt !== 1'b0) begin
            errors++;
            $display("FAIL watch_confirm_3: trading_halt got %b expected 0", trading_halt);
        end
        step();
        idle();
        vectors++;
        if ({trading_halt, halt_count, last_cause} !== {1'b1, 8'd1, 3'd2}) begin
            errors++;
            $display("FAIL watch_confirm_4: got halt=%b cnt=%0d cause=%0d expected 1/1/2",
                     trading_halt, halt_count, last_cause);
        end
    endtask

    task automatic test_retrigger();
        int halt_len;
        do_reset();
        set_alert(1'b1, 3'd7, 3'd7, 8'h80);
        step();
        idle();
        repeat (9) step();
        set_alert(1'b1, 3'd7, 3'd5, 8'h20);
        step();
        idle();
        vectors++;
        if ({trading_halt, halt_count, last_cause} !== {1'b1, 8'd2, 3'd5}) begin
            errors++;
            $display("FAIL retrigger_event: got halt=%b cnt=%0d cause=%0d expected 1/2/5",
                     trading_halt, halt_count, last_cause);
        end
        halt_len = 1;
        while (trading_halt === 1'b1 && halt_len < 100) begin
            step();
            if (trading_halt === 1'b1) halt_len++;
        end
        vectors++;
        if (halt_len != 16 || throttle !== 1'b1) begin
            errors++;
            $display("FAIL retrigger_len: got %0d throttle %b expected 16/1", halt_len, throttle);
        end
    endtask

    task automatic test_cooldown();
        do_reset();
        set_alert(1'b1, 3'd7, 3'd7, 8'h80);
        step();
        idle();
        repeat (15) step();
        step();
        vectors++;
        if (throttle !== 1'b1 || cb_state !== 2'b11) begin
            errors++;
            $display("FAIL cool_entry: throttle got %b state %b expected 1/11", throttle, cb_state);
        end
        repeat (2) step();
        set_alert(1'b1, 3'd5, 3'd3, 8'h08);
        step();
        idle();
        vectors++;
        if ({trading_halt, last_cause, halt_count} !== {1'b1, 3'd3, 8'd2}) begin
            errors++;
            $display("FAIL cool_retrip: got halt=%b cause=%0d cnt=%0d expected 1/3/2",
                     trading_halt, last_cause, halt_count);
        end
        set_alert(1'b1, 3'd7, 3'd7, 8'h80);
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 252) begin
                vectors++;
                if (halt_count !== 8'd254) begin
                    errors++;
                    $display("FAIL sat_pre: halt_count got %0d expected 254", halt_count);
                end
            end
        end
        idle();
        vectors++;
        if (halt_count !== 8'd255 || trading_halt !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: halt_count got %0d halt %b expected 255/1", halt_count, trading_halt);
        end
    endtask

    task automatic test_clr();
        do_reset();
        set_alert(1'b1, 3'd7, 3'd1, 8'h02);
        step();
        set_alert(1'b0, 3'd0, 3'd0, 8'h10);
        step();
        vectors++;
        if (sticky_bitmap !== 8'h12) begin
            errors++;
            $display("FAIL sticky_or: got %h expected 12", sticky_bitmap);
        end
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        vectors++;
        if ({cb_state, trading_halt, sticky_bitmap, halt_count, last_cause} !== {2'b00, 1'b0, 8'h00, 8'd1, 3'd1}) begin
            errors++;
            $display("FAIL clr_alone: got st=%b halt=%b sticky=%h cnt=%0d cause=%0d expected 00/0/00/1/1",
                     cb_state, trading_halt, sticky_bitmap, halt_count, last_cause);
        end
        repeat (20) step();
        vectors++;
        if (cb_state !== 2'b00) begin
            errors++;
            $display("FAIL clr_stays_normal: state got %b expected 00", cb_state);
        end
        set_alert(1'b1, 3'd7, 3'd7, 8'h80);
        step();
        set_alert(1'b1, 3'd7, 3'd6, 8'h40);
        clr = 1'b1;
        step();
        idle();
        vectors++;
        if ({cb_state, sticky_bitmap, halt_count, last_cause} !== {2'b10, 8'h40, 8'd3, 3'd6}) begin
            errors++;
            $display("FAIL clr_flash: got st=%b sticky=%h cnt=%0d cause=%0d expected 10/40/3/6",
                     cb_state, sticky_bitmap, halt_count, last_cause);
        end
    endtask

    initial begin
        test_reset();
        test_flash_cycle();
        test_watch();
        test_retrigger();
        test_cooldown();
        test_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/circuit_breaker.md
# circuit_breaker

Market circuit breaker sitting directly downstream of the anomaly detector. It consumes the per-cycle alert bundle (`alert_any`, `alert_priority`, `alert_type`, `alert_bitmap`) and turns transient, combinational alert flags into a stable trading-control state. Outputs are a registered trading halt, a throttle flag, a sticky alert log, and a halt-event counter. The order book and the top-level output mux consume these outputs.

## Interface

Parameters:
- `CONFIRM_CYCLES`, default 4: consecutive severe-alert cycles required to trip from WATCH.
- `HALT_CYCLES`, default 1024: length of a halt in cycles (≥1).
- `COOL_CYCLES`, default 256: length of the cooldown in cycles (≥1).
- `TIMER_W`, default 16: hold-timer width; must hold max(HALT_CYCLES, COOL_CYCLES)−1.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alert_any`  in  1  any detector active.
- `alert_priority`  in  3  priority of the highest active alert; 7 means flash crash.
- `alert_type`  in  3  type of the highest active alert.
- `alert_bitmap`  in  8  all detector flags.
- `clr`  in  1  operator clear, single-cycle pulse.
- `trading_halt`  out  1  order matching must be suppressed.
- `throttle`  out  1  cooldown active; reduced-rate trading.
- `cb_state`  out  2  current state: 00 NORMAL, 01 WATCH, 10 HALT, 11 COOLDOWN.
- `last_cause`  out  3  `alert_type` that caused the most recent HALT entry.
- `sticky_bitmap`  out  8  OR-accumulated `alert_bitmap` since the last reset or clear.
- `halt_count`  out  8  number of HALT entries, saturating at 255.

## Operation

Definitions:
- Severe alert: `alert_any && alert_priority >= 4`.
- Flash: `alert_any && alert_priority == 7`.

State machine:
- **NORMAL**
  - flash → HALT.
  - severe → WATCH, with `confirm_cnt` = 1.
  - otherwise stay.
- **WATCH**
  - flash → HALT.
  - severe → `confirm_cnt` +1; when the incremented value reaches CONFIRM_CYCLES, go to HALT.
  - non-severe → NORMAL, `confirm_cnt` cleared.
- **HALT**
  - Timer loads HALT_CYCLES−1 on entry and decrements each cycle.
  - Flash reloads the timer (retrigger) and counts as a new HALT entry.
  - Timer reaching 0 with no flash in that cycle → COOLDOWN.
- **COOLDOWN**
  - Timer loads COOL_CYCLES−1 on entry.
  - Severe alert → HALT.
  - Timer reaching 0 → NORMAL.

Every HALT entry or retrigger:
- `halt_count` increments, saturating at 255.
- `last_cause` ← `alert_type`.

`clr` behaviour:
- Forces NORMAL, clears the timer, `confirm_cnt` and `sticky_bitmap`.
- Does not clear `halt_count` or `last_cause`.
- If flash is present in the same cycle, flash wins: the block goes to HALT and `sticky_bitmap` ← `alert_bitmap`.

Sticky log: otherwise, every cycle `sticky_bitmap` ← `sticky_bitmap | alert_bitmap`.

Output decode from state: `trading_halt` = (HALT), `throttle` = (COOLDOWN).

## Timing

- All outputs are registered.
- An alert sampled at edge N is reflected in the outputs after edge N.
- Flash to `trading_halt` latency: 1 cycle.
- Severe to `trading_halt` from NORMAL: CONFIRM_CYCLES cycles, given continuously severe input.
- A HALT with no retrigger lasts exactly HALT_CYCLES cycles, then exactly COOL_CYCLES cycles of COOLDOWN.
- CONFIRM_CYCLES = 1: the first severe sample goes directly to HALT, bypassing WATCH.
- Reset (asynchronous, any state, including mid-HALT):
  - state NORMAL; `trading_halt` 0; `throttle` 0; `cb_state` 00.
  - `last_cause` 0; `sticky_bitmap` 0; `halt_count` 0.
  - timer 0; `confirm_cnt` 0.
- Inputs are treated as synchronous to `clk`; no extra input synchronisation.

## Structure

- Shared package `nanotrade_pkg`:
  - state encodings (`CB_NORMAL`, `CB_WATCH`, `CB_HALT`, `CB_COOLDOWN`).
  - `PRIO_FLASH` = 3'd7, `PRIO_SEVERE` = 3'd4.
  - Alert-type codes matching the detector bitmap order.
- Sub-module `hold_timer`:
  - parameterised TIMER_W down-counter.
  - `load`/`value` inputs, `expired` output (count==0 while running).
  - Used for both the HALT and COOLDOWN phases.
- FSM, confirm counter, sticky log and event counter live in `circuit_breaker`.

## Test plan

Parameters for all scenarios: CONFIRM=4, HALT=16, COOL=8.

1. **Reset mid-HALT.** Assert `rst_n`=0 during HALT → all outputs 0 immediately; NORMAL after release.
2. **Flash trip and full cycle.** Single-cycle priority=7, type=7, bitmap=0x80 → next cycle `trading_halt`=1, `last_cause`=7, `halt_count`=1, `sticky_bitmap`=0x80. Then `trading_halt` stays 1 for 16 cycles, `throttle`=1 for 8 cycles, then NORMAL.
3. **WATCH confirm and abort.**
   - Priority 4 held for 3 cycles then dropped → WATCH, then back to NORMAL; no halt.
   - Priority 4 held for 4 cycles → HALT after the 4th sample.
4. **Flash retrigger.** Flash again at HALT cycle 10 → halt extends 16 cycles from the retrigger; `halt_count`=2.
5. **COOLDOWN re-trip and `halt_count` saturation.**
   - Priority 5 at cooldown cycle 3 → HALT, `last_cause` = that type.
   - 300 flash retriggers → `halt_count`=255.
6. **`clr` conflicts.**
   - `clr` alone during HALT → NORMAL, `sticky_bitmap`=0.
   - `clr` plus flash in the same cycle → HALT, `sticky_bitmap`=`alert_bitmap`.
